bicubic_hscale_element: RTL and testbench

- Parametrised horizontal 4x upscaler; successor to the fixed 24-bit processing element.
- Accepts one CHANNELS-wide pixel per input handshake from the access controller.
- Emits four interpolated pixels per output handshake, at output phases 0, 1/4, 1/2 and 3/4.
- Supports per-row selection of bicubic (a = -0.5) or nearest-neighbour mode; handles row edges by replicating edge pixels.

---
 rtl/bicubic_hscale_element.sv | 187 ++++++++++++++++++
 tb/tb_bicubic_hscale_element.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_hscale_element.sv
// -----------------------------------------------------------------------------
// bicubic_hscale_element
//   Horizontal 4x upscaler. One CHANNELS-wide pixel enters per input handshake.
//   Four interpolated pixels (phases 0, 1/4, 1/2, 3/4) leave per output beat.
//   Each row runs in bicubic (a = -0.5) or nearest mode, chosen at row start.
//   Row edges are handled by replicating the first and last pixels.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cfg_nearest       1 = nearest, 0 = bicubic; sampled on column 0 only
//   upsp_ac_rready    block can take an input pixel
//   ac_upsp_rdata     input pixel, channel 0 in the LSBs
//   ac_upsp_rvalid    input pixel valid
//   ac_upsp_wready    downstream takes the output beat
//   upsp_ac_wdata     four output pixels, phase 0 in the LSBs
//   upsp_ac_wvalid    output beat valid
//   cur_col_cnt       index k of the next output beat in the row
//   row_done          one-cycle pulse after the last beat of a row is taken
// -----------------------------------------------------------------------------
module bicubic_hscale_element #(
    parameter int CH_WIDTH  = 8,
    parameter int CHANNELS  = 3,
    parameter int IMG_WIDTH = 960,
    parameter int COL_CNT_W = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_nearest,
    output logic                           upsp_ac_rready,
    input  logic [CH_WIDTH*CHANNELS-1:0]   ac_upsp_rdata,
    input  logic                           ac_upsp_rvalid,
    input  logic                           ac_upsp_wready,
    output logic [4*CH_WIDTH*CHANNELS-1:0] upsp_ac_wdata,
    output logic                           upsp_ac_wvalid,
    output logic [COL_CNT_W-1:0]           cur_col_cnt,
    output logic                           row_done
);

    localparam int PIX_W   = CH_WIDTH * CHANNELS;
    localparam int ACC_W   = CH_WIDTH + 9;
    localparam int PIX_MAX = (1 << CH_WIDTH) - 1;
    localparam logic [COL_CNT_W-1:0] LAST_COL = COL_CNT_W'(IMG_WIDTH - 1);

    // Bicubic taps (x128) for P[k-1], P[k], P[k+1], P[k+2], one row per phase.
    localparam int COEF [4][4] = '{
        '{  0, 128,   0,  0},
        '{ -9, 111,  29, -3},
        '{ -8,  72,  72, -8},
        '{ -3,  29, 111, -9}
    };

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t               state, state_nxt;
    // hist holds P[k], P[k+1], P[k+2] of the beat last loaded; the incoming
    // pixel completes the next window, so P[k-1] never needs its own slot.
    logic [PIX_W-1:0]     hist [3];
    logic                 mode_nearest;
    logic [COL_CNT_W-1:0] in_col;
    logic [1:0]           flush_cnt;
    logic                 in_fire, out_fire, out_free, gen_beat;
    logic [PIX_W-1:0]     shift_in;
    logic [4*PIX_W-1:0]   beat_nxt;

    function automatic logic [CH_WIDTH-1:0] cubic_ch(
        input logic [4*CH_WIDTH-1:0] taps,
        input int                    ph
    );
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] rnd;
        sum = '0;
        for (int t = 0; t < 4; t++)
            sum = sum + ACC_W'(COEF[ph][t]) * $signed({9'd0, taps[t*CH_WIDTH +: CH_WIDTH]});
        rnd = (sum + ACC_W'(64)) >>> 7;
        if (rnd[ACC_W-1])             return '0;
        if (rnd > ACC_W'(PIX_MAX))    return '1;
        return rnd[CH_WIDTH-1:0];
    endfunction

    function automatic logic [4*PIX_W-1:0] make_beat(
        input logic [PIX_W-1:0] p0, p1, p2, p3,
        input logic             nearest
    );
        logic [4*PIX_W-1:0]    beat;
        logic [4*CH_WIDTH-1:0] taps;
        beat = '0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                taps = {p3[ch*CH_WIDTH +: CH_WIDTH], p2[ch*CH_WIDTH +: CH_WIDTH],
                        p1[ch*CH_WIDTH +: CH_WIDTH], p0[ch*CH_WIDTH +: CH_WIDTH]};
                beat[ph*PIX_W + ch*CH_WIDTH +: CH_WIDTH] =
                    nearest ? p1[ch*CH_WIDTH +: CH_WIDTH] : cubic_ch(taps, ph);
            end
        end
        return beat;
    endfunction

    assign out_free = !upsp_ac_wvalid || ac_upsp_wready;
    assign out_fire = upsp_ac_wvalid && ac_upsp_wready;
    assign in_fire  = ac_upsp_rvalid && upsp_ac_rready;

    // Held low during reset so nothing is offered as accepted while state clears.
    assign upsp_ac_rready = rst_n && ((state == IDLE) || (state == FILL) ||
                                      (state == RUN && out_free));

    assign beat_nxt = make_beat(hist[0], hist[1], hist[2], shift_in, mode_nearest);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        gen_beat  = 1'b0;
        shift_in  = ac_upsp_rdata;
        case (state)
            IDLE:  if (in_fire) state_nxt = FILL;
            FILL:  if (in_fire) state_nxt = (in_col == LAST_COL) ? FLUSH : RUN;
            RUN: begin
                gen_beat = in_fire;
                if (in_fire && in_col == LAST_COL) state_nxt = FLUSH;
            end
            FLUSH: begin
                // Right edge: replicate P[W-1] into the window for the last two beats.
                shift_in = hist[2];
                gen_beat = out_free && (flush_cnt != 2'd2);
                if (out_fire && cur_col_cnt == LAST_COL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the window is three plain flops, not a RAM, so it can be
            // cleared on reset and no stale pixel can leak into a new row.
            for (int i = 0; i < 3; i++) hist[i] <= '0;
            mode_nearest   <= 1'b0;
            in_col         <= '0;
            flush_cnt      <= '0;
            upsp_ac_wvalid <= 1'b0;
            upsp_ac_wdata  <= '0;
            cur_col_cnt    <= '0;
            row_done       <= 1'b0;
        end else begin
            row_done <= 1'b0;

            if (state == IDLE && in_fire) begin
                // Left edge: column 0 stands in for P[-1] as well as P[0].
                mode_nearest <= cfg_nearest;
                hist[1]      <= ac_upsp_rdata;
                hist[2]      <= ac_upsp_rdata;
                in_col       <= COL_CNT_W'(1);
                flush_cnt    <= '0;
            end else if ((state == FILL && in_fire) || gen_beat) begin
                hist[0] <= hist[1];
                hist[1] <= hist[2];
                hist[2] <= shift_in;
                if (in_fire) in_col <= in_col + COL_CNT_W'(1);
            end

            if (gen_beat) begin
                upsp_ac_wdata  <= beat_nxt;
                upsp_ac_wvalid <= 1'b1;
            end else if (out_fire) begin
                upsp_ac_wvalid <= 1'b0;
            end

            if (gen_beat && state == FLUSH) flush_cnt <= flush_cnt + 2'd1;

            if (out_fire) begin
                if (cur_col_cnt == LAST_COL) begin
                    cur_col_cnt <= '0;
                    row_done    <= 1'b1;
                end else begin
                    cur_col_cnt <= cur_col_cnt + COL_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bicubic_hscale_element.sv
// -----------------------------------------------------------------------------
// tb_bicubic_hscale_element
//   Two instances share clk_tb/rst_n: index 0 has IMG_WIDTH=4, index 1 has
//   IMG_WIDTH=8. A reference model fills a scoreboard queue when a row is
//   driven; beats are popped and compared as the DUT hands them over. A small
//   table of hand-computed vectors pins specific phases on the W=4 instance.
// -----------------------------------------------------------------------------
module tb_bicubic_hscale_element;

    localparam int CW  = 8;
    localparam int CH  = 3;
    localparam int PW  = CW * CH;
    localparam int BW  = 4 * PW;
    localparam int CCW = 12;

    localparam int COEF [4][4] = '{
        '{  0, 128,   0,  0},
        '{ -9, 111,  29, -3},
        '{ -8,  72,  72, -8},
        '{ -3,  29, 111, -9}
    };

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic                   rst_n;
    logic [1:0]             cfg, rvalid, rready, wready, wvalid, done;
    logic [1:0][PW-1:0]     rdata;
    logic [1:0][BW-1:0]     wdata;
    logic [1:0][CCW-1:0]    col;

    bicubic_hscale_element #(.CH_WIDTH(CW), .CHANNELS(CH), .IMG_WIDTH(4), .COL_CNT_W(CCW)) u_w4 (
        .clk(clk_tb), .rst_n(rst_n), .cfg_nearest(cfg[0]),
        .upsp_ac_rready(rready[0]), .ac_upsp_rdata(rdata[0]), .ac_upsp_rvalid(rvalid[0]),
        .ac_upsp_wready(wready[0]), .upsp_ac_wdata(wdata[0]), .upsp_ac_wvalid(wvalid[0]),
        .cur_col_cnt(col[0]), .row_done(done[0]));

    bicubic_hscale_element #(.CH_WIDTH(CW), .CHANNELS(CH), .IMG_WIDTH(8), .COL_CNT_W(CCW)) u_w8 (
        .clk(clk_tb), .rst_n(rst_n), .cfg_nearest(cfg[1]),
        .upsp_ac_rready(rready[1]), .ac_upsp_rdata(rdata[1]), .ac_upsp_rvalid(rvalid[1]),
        .ac_upsp_wready(wready[1]), .upsp_ac_wdata(wdata[1]), .upsp_ac_wvalid(wvalid[1]),
        .cur_col_cnt(col[1]), .row_done(done[1]));

    typedef struct {
        logic [BW-1:0] data;
        int            k;
    } exp_t;

    typedef struct {
        int px  [4];
        int beat;
        int exp [4];
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          exp_q [$];
    logic [PW-1:0] row_px    [16];
    logic [BW-1:0] got_beats [16];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] grey(input int v);
        logic [CW-1:0] b;
        b = CW'(v);
        return {b, b, b};
    endfunction

    // Reference: window indices clamped to [0, w-1] give edge replication.
    function automatic logic [BW-1:0] model_beat(input int w, input int k, input bit nearest);
        logic [BW-1:0] beat;
        int idx, acc, val;
        beat = '0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < CH; c++) begin
                acc = 0;
                for (int t = 0; t < 4; t++) begin
                    idx = k - 1 + t;
                    if (idx < 0)     idx = 0;
                    if (idx > w - 1) idx = w - 1;
                    acc += COEF[ph][t] * int'(row_px[idx][c*CW +: CW]);
                end
                val = (acc + 64) >>> 7;
                if (val < 0)   val = 0;
                if (val > 255) val = 255;
                if (nearest) val = int'(row_px[k][c*CW +: CW]);
                beat[ph*PW + c*CW +: CW] = CW'(val);
            end
        end
        return beat;
    endfunction

    // Streams row_px[0..w-1] into instance sel and scoreboards every beat.
    task automatic run_row(input int sel, input int w, input bit nearest,
                           input bit rand_ready, input bit toggle_cfg);
        int            in_idx, beats, pulses;
        bit            stalled;
        logic [BW-1:0] held;
        exp_t          e;
        for (int k = 0; k < w; k++) exp_q.push_back('{model_beat(w, k, nearest), k});
        in_idx = 0; beats = 0; pulses = 0; stalled = 1'b0; held = '0;
        cfg[sel] = nearest;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_tb);
            wready[sel] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rvalid[sel] = (in_idx < w);
            rdata[sel]  = (in_idx < w) ? row_px[in_idx] : '0;
            if (toggle_cfg && in_idx > 0) cfg[sel] = ~cfg[sel];
            #1;
            if (done[sel]) pulses++;
            if (beats == w) begin
                check("row_done_after_last", done[sel], 1'b1);
                break;
            end
            if (stalled) begin
                check("stall_hold_valid", wvalid[sel], 1'b1);
                check("stall_hold_data", wdata[sel], held);
            end
            if (wvalid[sel] && !wready[sel]) check("rready_low_when_full", rready[sel], 1'b0);
            stalled = wvalid[sel] && !wready[sel];
            held    = wdata[sel];
            if (wvalid[sel] && wready[sel]) begin
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", wdata[sel], e.data);
                    check("beat_col", col[sel], e.k);
                end
                if (beats < 16) got_beats[beats] = wdata[sel];
                beats++;
            end
            if (rvalid[sel] && rready[sel]) in_idx++;
        end
        rvalid[sel] = 1'b0;
        wready[sel] = 1'b1;
        check("beat_count", beats, w);
        check("row_done_pulses", pulses, 1);
        check("col_cnt_wrap", col[sel], 0);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs [6];
        int   in_idx;

        // Hand-derived expectations (phase 0 first), channel value replicated x3.
        vecs[0] = '{'{100, 100, 100, 100}, 2, '{100, 100, 100, 100}};
        vecs[1] = '{'{  0,  10,  20,  30}, 0, '{  0,   2,   4,   7}};
        // phase 3: (290 + 2220 - 270 + 64) >>> 7 = 18
        vecs[2] = '{'{  0,  10,  20,  30}, 1, '{ 10,  13,  15,  18}};
        vecs[3] = '{'{  0,  10,  20,  30}, 3, '{ 30,  31,  31,  30}};
        // raw 279 / 287 / 279 saturate high
        vecs[4] = '{'{  0, 255, 255,   0}, 1, '{255, 255, 255, 255}};
        // raw -24 / -32 / -24 saturate low
        vecs[5] = '{'{255,   0,   0, 255}, 1, '{  0,   0,   0,   0}};

        rst_n  = 1'b0;
        cfg    = '0;
        rvalid = '0;
        rdata  = '0;
        wready = 2'b11;

        repeat (2) @(negedge clk_tb);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_rready", rready[s], 1'b0);
            check("reset_wvalid", wvalid[s], 1'b0);
            check("reset_wdata", wdata[s], '0);
            check("reset_col", col[s], 0);
            check("reset_row_done", done[s], 1'b0);
        end
        @(negedge clk_tb);
        rst_n = 1'b1;

        // Constant, ramp and clamp rows on the W=4 instance.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) row_px[i] = grey(vecs[v].px[i]);
            run_row(0, 4, 1'b0, 1'b0, 1'b0);
            for (int ph = 0; ph < 4; ph++)
                check($sformatf("vec%0d_phase%0d", v, ph),
                      got_beats[vecs[v].beat][ph*PW +: PW], grey(vecs[v].exp[ph]));
        end

        // Backpressure: random wready on W=8, two rows back to back.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) row_px[i] = PW'($urandom);
            run_row(1, 8, 1'b0, 1'b1, 1'b0);
        end

        // Mode switch with mid-row cfg toggling: nearest row then bicubic row.
        for (int i = 0; i < 8; i++) row_px[i] = PW'($urandom);
        run_row(1, 8, 1'b1, 1'b0, 1'b1);
        for (int ph = 0; ph < 4; ph++)
            check("nearest_replicate", got_beats[5][ph*PW +: PW], row_px[5]);
        for (int i = 0; i < 8; i++) row_px[i] = PW'($urandom);
        run_row(1, 8, 1'b0, 1'b0, 1'b1);

        // Reset mid-row: three inputs with the output stalled, then reset.
        wready[1] = 1'b0;
        in_idx    = 0;
        for (int cyc = 0; cyc < 50 && in_idx < 3; cyc++) begin
            @(negedge clk_tb);
            rvalid[1] = 1'b1;
            rdata[1]  = row_px[in_idx];
            #1;
            if (rvalid[1] && rready[1]) in_idx++;
        end
        check("partial_inputs", in_idx, 3);
        @(negedge clk_tb);
        rvalid[1] = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk_tb);
        #1;
        check("midrow_reset_rready", rready[1], 1'b0);
        check("midrow_reset_wvalid", wvalid[1], 1'b0);
        check("midrow_reset_col", col[1], 0);
        check("midrow_reset_wdata", wdata[1], '0);
        @(negedge clk_tb);
        rst_n     = 1'b1;
        wready[1] = 1'b1;
        for (int i = 0; i < 8; i++) row_px[i] = PW'($urandom);
        run_row(1, 8, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
